beam_frame_sequencer: RTL and testbench

Four-channel alignment and weight-scheduling controller sitting in front of the beamforming adder datapath. It collects one 128-bit beat from each of the four input channels (00, 01, 20, 21), releases them to the adder as a single aligned 512-bit beat, and tracks frame boundaries using last. It also double-buffers the eight beam weights so the active set changes only between frames, never inside one.

---
 rtl/beam_frame_sequencer_if.sv | 24 ++
 rtl/beam_frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_beam_frame_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beam_frame_sequencer_if.sv
// Valid/ready beat channel with an end-of-frame marker, shared by the four
// input channels and the aligned output of the beam frame sequencer.
interface beam_frame_sequencer_if #(
   parameter int DATA_WIDTH = 128
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  last;
   logic                  ready;

   modport master (
      output data,
      output valid,
      output last,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  last,
      output ready
   );
endinterface

// File: rtl/beam_frame_sequencer.sv
// Aligns one beat from each of four channels into a single wide beat for the
// beamforming adder, tracks frame boundaries and swaps weights only between frames.
module beam_frame_sequencer #(
   parameter int SDATA_WIDTH  = 128,
   parameter int WEIGHT_WIDTH = 8
) (
   input  logic                              clock,
   input  logic                              resetn,
   beam_frame_sequencer_if.slave             s00_axi,
   beam_frame_sequencer_if.slave             s01_axi,
   beam_frame_sequencer_if.slave             s20_axi,
   beam_frame_sequencer_if.slave             s21_axi,
   beam_frame_sequencer_if.master            m_axi,
   input  logic [8*(WEIGHT_WIDTH+1)-1:0]     cfg_weights,
   input  logic                              cfg_valid,
   output logic                              cfg_ready,
   output logic [8*(WEIGHT_WIDTH+1)-1:0]     act_weights,
   output logic [15:0]                       frame_count,
   output logic                              align_err,
   input  logic                              err_clear,
   output logic                              busy
);

   localparam int NW    = 8;
   localparam int WBITS = NW * (WEIGHT_WIDTH + 1);

   typedef enum logic {
      W_EMPTY,
      W_PENDING
   } wstate_t;

   logic [SDATA_WIDTH-1:0]   ch_data   [4];
   logic [3:0]               ch_valid;
   logic [3:0]               ch_last;
   logic [3:0]               ch_ready;
   logic [3:0]               hand;

   logic [SDATA_WIDTH-1:0]   held_data [4];
   logic [3:0]               held_last;
   logic [3:0]               held;

   logic [4*SDATA_WIDTH-1:0] out_data;
   logic                     out_valid;
   logic                     out_last;

   logic                     fire;
   logic                     out_hs;
   logic                     mid_frame;
   logic                     mid_next;
   logic                     last_mismatch;

   wstate_t                  wstate;
   logic [WBITS-1:0]         shadow;

   assign ch_data[0] = s00_axi.data;
   assign ch_data[1] = s01_axi.data;
   assign ch_data[2] = s20_axi.data;
   assign ch_data[3] = s21_axi.data;
   assign ch_valid   = {s21_axi.valid, s20_axi.valid, s01_axi.valid, s00_axi.valid};
   assign ch_last    = {s21_axi.last, s20_axi.last, s01_axi.last, s00_axi.last};

   assign s00_axi.ready = ch_ready[0];
   assign s01_axi.ready = ch_ready[1];
   assign s20_axi.ready = ch_ready[2];
   assign s21_axi.ready = ch_ready[3];

   assign m_axi.data  = out_data;
   assign m_axi.valid = out_valid;
   assign m_axi.last  = out_last;

   // A held channel may accept again only on the edge that drains its beat into the output.
   assign fire          = (&held) && (!out_valid || m_axi.ready);
   assign ch_ready      = ~held | {4{fire}};
   assign hand          = ch_valid & ch_ready;
   assign out_hs        = out_valid && m_axi.ready;
   assign mid_next      = out_hs ? !out_last : mid_frame;
   assign last_mismatch = (|held_last) && !(&held_last);
   assign busy          = (|held) || out_valid || mid_frame;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         held      <= '0;
         held_last <= '0;
         for (int i = 0; i < 4; i++) begin
            held_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (hand[i]) begin
               held_data[i] <= ch_data[i];
               held_last[i] <= ch_last[i];
            end
         end
         held <= (held & ~{4{fire}}) | hand;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (fire) begin
         out_data  <= {held_data[3], held_data[2], held_data[1], held_data[0]};
         out_valid <= 1'b1;
         out_last  <= held_last[0];
      end else if (out_hs) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         frame_count <= '0;
         mid_frame   <= 1'b0;
         align_err   <= 1'b0;
      end else begin
         mid_frame <= mid_next;
         if (out_hs && out_last) begin
            frame_count <= frame_count + 16'd1;
         end
         if (fire && last_mismatch) begin
            align_err <= 1'b1;
         end else if (err_clear) begin
            align_err <= 1'b0;
         end
      end
   end

   // Pending weights wait until the datapath is between frames after this edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wstate      <= W_EMPTY;
         cfg_ready   <= 1'b1;
         shadow      <= '0;
         act_weights <= '0;
      end else begin
         case (wstate)
            W_EMPTY: begin
               if (cfg_valid) begin
                  shadow    <= cfg_weights;
                  wstate    <= W_PENDING;
                  cfg_ready <= 1'b0;
               end
            end
            W_PENDING: begin
               if (!mid_next) begin
                  act_weights <= shadow;
                  wstate      <= W_EMPTY;
                  cfg_ready   <= 1'b1;
               end
            end
            default: begin
               wstate    <= W_EMPTY;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_beam_frame_sequencer.sv
// Testbench for beam_frame_sequencer: directed vector table, weight-swap and
// reset sequences, then randomized traffic against a queue-based reference model.
module tb_beam_frame_sequencer;

   localparam int SW   = 128;
   localparam int WB   = 72;
   localparam int NVEC = 17;

   typedef logic [SW:0] beat_t;

   typedef struct {
      logic [3:0]  wvalid;
      logic [3:0]  wlast;
      logic        rready;
      logic        eclr;
      logic [3:0]  ewready;
      logic        ervalid;
      logic        erlast;
      logic [15:0] eframes;
      logic        eerr;
      logic        ebusy;
   } vec_t;

   logic          clock = 1'b0;
   logic          resetn;
   logic [3:0]    tbValid;
   logic [3:0]    tbLast;
   logic [SW-1:0] tbData [4];
   logic          tbReady;
   logic [WB-1:0] cfgWeights;
   logic          cfgValid;
   logic          errClear;
   logic          cfgReady;
   logic [WB-1:0] actWeights;
   logic [15:0]   frameCount;
   logic          alignErr;
   logic          busy;
   wire  [3:0]    dutReady;

   int tests;
   int fails;
   int dutOutCount;
   int mOutCount;

   beat_t           mq [4][$];
   logic            mVld;
   logic            mLast;
   logic            mErr;
   logic            mMid;
   logic            mPend;
   logic [4*SW-1:0] mData;
   logic [15:0]     mFrames;
   logic [WB-1:0]   mShadow;
   logic [WB-1:0]   mAct;

   vec_t            vecs [NVEC];
   logic [WB-1:0]   wA;
   logic [WB-1:0]   wB;
   logic [4*SW-1:0] expBeat;
   logic [3:0]      rv;
   logic [3:0]      rl;
   logic            lastAll;

   beam_frame_sequencer_if #(.DATA_WIDTH(SW))   s00Axi ();
   beam_frame_sequencer_if #(.DATA_WIDTH(SW))   s01Axi ();
   beam_frame_sequencer_if #(.DATA_WIDTH(SW))   s20Axi ();
   beam_frame_sequencer_if #(.DATA_WIDTH(SW))   s21Axi ();
   beam_frame_sequencer_if #(.DATA_WIDTH(4*SW)) mAxi ();

   assign s00Axi.data  = tbData[0];
   assign s01Axi.data  = tbData[1];
   assign s20Axi.data  = tbData[2];
   assign s21Axi.data  = tbData[3];
   assign s00Axi.valid = tbValid[0];
   assign s01Axi.valid = tbValid[1];
   assign s20Axi.valid = tbValid[2];
   assign s21Axi.valid = tbValid[3];
   assign s00Axi.last  = tbLast[0];
   assign s01Axi.last  = tbLast[1];
   assign s20Axi.last  = tbLast[2];
   assign s21Axi.last  = tbLast[3];
   assign mAxi.ready   = tbReady;
   assign dutReady     = {s21Axi.ready, s20Axi.ready, s01Axi.ready, s00Axi.ready};

   beam_frame_sequencer #(
      .SDATA_WIDTH (SW),
      .WEIGHT_WIDTH(8)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .s00_axi     (s00Axi),
      .s01_axi     (s01Axi),
      .s20_axi     (s20Axi),
      .s21_axi     (s21Axi),
      .m_axi       (mAxi),
      .cfg_weights (cfgWeights),
      .cfg_valid   (cfgValid),
      .cfg_ready   (cfgReady),
      .act_weights (actWeights),
      .frame_count (frameCount),
      .align_err   (alignErr),
      .err_clear   (errClear),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [4*SW-1:0] got, input logic [4*SW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic rr,
                                input logic cv, input logic [WB-1:0] cw, input logic ec);
      tbValid    = v;
      tbLast     = l;
      tbReady    = rr;
      cfgValid   = cv;
      cfgWeights = cw;
      errClear   = ec;
      #2;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) mq[i].delete();
      mVld    = 1'b0;
      mLast   = 1'b0;
      mErr    = 1'b0;
      mMid    = 1'b0;
      mPend   = 1'b0;
      mData   = '0;
      mFrames = '0;
      mShadow = '0;
      mAct    = '0;
   endtask

   task automatic randomData();
      for (int i = 0; i < 4; i++) tbData[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Compare the DUT against the model for the current inputs, then advance both one edge.
   task automatic tick();
      logic       fire;
      logic [3:0] expReady;
      logic       expBusy;
      logic       outHs;
      logic       midNext;
      logic       errSet;
      beat_t      f [4];
      fire    = 1'b1;
      expBusy = mVld || mMid;
      for (int i = 0; i < 4; i++) begin
         if (mq[i].size() != 1) fire = 1'b0;
         if (mq[i].size() != 0) expBusy = 1'b1;
      end
      fire = fire && (!mVld || tbReady);
      for (int i = 0; i < 4; i++) expReady[i] = (mq[i].size() == 0) || fire;

      checkOutput("wready", dutReady, expReady);
      checkOutput("rvalid", mAxi.valid, mVld);
      checkOutput("rdata", mAxi.data, mData);
      checkOutput("rlast", mAxi.last, mLast);
      checkOutput("frame_count", frameCount, mFrames);
      checkOutput("align_err", alignErr, mErr);
      checkOutput("cfg_ready", cfgReady, !mPend);
      checkOutput("act_weights", actWeights, mAct);
      checkOutput("busy", busy, expBusy);

      if (mAxi.valid && tbReady) dutOutCount++;
      outHs = mVld && tbReady;
      if (outHs) mOutCount++;
      midNext = outHs ? !mLast : mMid;
      if (outHs && mLast) mFrames++;
      mMid   = midNext;
      errSet = 1'b0;
      if (fire) begin
         for (int i = 0; i < 4; i++) f[i] = mq[i].pop_front();
         mData  = {f[3][SW-1:0], f[2][SW-1:0], f[1][SW-1:0], f[0][SW-1:0]};
         mLast  = f[0][SW];
         errSet = !((f[0][SW] == f[1][SW]) && (f[0][SW] == f[2][SW]) && (f[0][SW] == f[3][SW]));
         mVld   = 1'b1;
      end else if (outHs) begin
         mVld = 1'b0;
      end
      if (errSet) mErr = 1'b1;
      else if (errClear) mErr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (tbValid[i] && expReady[i]) mq[i].push_back({tbLast[i], tbData[i]});
      end
      if (mPend) begin
         if (!midNext) begin
            mAct  = mShadow;
            mPend = 1'b0;
         end
      end else if (cfgValid) begin
         mShadow = cfgWeights;
         mPend   = 1'b1;
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      dutOutCount = 0;
      mOutCount   = 0;
      tbValid     = '0;
      tbLast      = '0;
      tbReady     = 1'b0;
      cfgValid    = 1'b0;
      cfgWeights  = '0;
      errClear    = 1'b0;
      for (int i = 0; i < 4; i++) tbData[i] = '0;
      resetn = 1'b0;
      modelReset();
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;

      // wvalid, wlast, rready, err_clear | wready, rvalid, rlast, frames, err, busy
      vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
      vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1};
      vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[4]  = '{4'b1111, 4'b1011, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[5]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1};
      vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1};
      vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1};
      vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1};
      vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 16'd2, 1'b0, 1'b1};
      vecs[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1};
      vecs[11] = '{4'b1011, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1};
      vecs[12] = '{4'b1011, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1};
      vecs[13] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1};
      vecs[14] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1};
      vecs[15] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 16'd2, 1'b0, 1'b1};
      vecs[16] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0};

      for (int i = 0; i < 4; i++) tbData[i] = {16{8'((i + 1) * 17)}};
      expBeat = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
      for (int r = 0; r < NVEC; r++) begin
         applyStimulus(vecs[r].wvalid, vecs[r].wlast, vecs[r].rready, 1'b0, '0, vecs[r].eclr);
         checkOutput("vec_wready", dutReady, vecs[r].ewready);
         checkOutput("vec_rvalid", mAxi.valid, vecs[r].ervalid);
         checkOutput("vec_rlast", mAxi.last, vecs[r].erlast);
         checkOutput("vec_frames", frameCount, vecs[r].eframes);
         checkOutput("vec_align_err", alignErr, vecs[r].eerr);
         checkOutput("vec_busy", busy, vecs[r].ebusy);
         if (r == 2) checkOutput("vec_first_rdata", mAxi.data, expBeat);
         tick();
      end

      wA = 72'({$urandom, $urandom, $urandom});
      wB = ~wA;
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, wA, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("idle_swap_act", actWeights, wA);
      tick();
      for (int c = 1; c <= 12; c++) begin
         randomData();
         applyStimulus((c <= 8) ? 4'b1111 : 4'b0000, (c == 8) ? 4'b1111 : 4'b0000, 1'b1,
                       (c == 3) ? 1'b1 : 1'b0, wB, 1'b0);
         checkOutput("frame_act", actWeights, (c - 1 >= 10) ? wB : wA);
         checkOutput("frame_cfg_ready", cfgReady, (c - 1 >= 3 && c - 1 < 10) ? 1'b0 : 1'b1);
         tick();
      end

      randomData();
      applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, wA, 1'b0);
      tick();
      randomData();
      applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("pre_reset_cfg_ready", cfgReady, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      resetn = 1'b0;
      #1;
      checkOutput("reset_rvalid", mAxi.valid, 1'b0);
      checkOutput("reset_rdata", mAxi.data, '0);
      checkOutput("reset_rlast", mAxi.last, 1'b0);
      checkOutput("reset_act", actWeights, '0);
      checkOutput("reset_frames", frameCount, 16'd0);
      checkOutput("reset_align_err", alignErr, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_cfg_ready", cfgReady, 1'b1);
      checkOutput("reset_wready", dutReady, 4'b1111);
      modelReset();
      @(posedge clock);
      #1;
      resetn = 1'b1;
      randomData();
      expBeat = {tbData[3], tbData[2], tbData[1], tbData[0]};
      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("post_reset_rvalid", mAxi.valid, 1'b1);
      checkOutput("post_reset_rdata", mAxi.data, expBeat);
      checkOutput("post_reset_rlast", mAxi.last, 1'b1);
      tick();

      for (int n = 0; n < 3000; n++) begin
         lastAll = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < 4; i++) rv[i] = ($urandom_range(0, 99) < 75);
         rl = ($urandom_range(0, 19) == 0) ? 4'($urandom) : {4{lastAll}};
         randomData();
         applyStimulus(rv, rl, ($urandom_range(0, 99) < 70), ($urandom_range(0, 9) == 0),
                       72'({$urandom, $urandom, $urandom}), ($urandom_range(0, 19) == 0));
         tick();
      end

      checkOutput("beat_count", dutOutCount, mOutCount);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
